// File: rtl/sd_frame_unpacker.sv
// Word-to-byte unpacker between the SD file reader and the cell-state RAM.
// Optional macro SD_UNPACK_BITREV_EN: bit-reverse every byte (MSB-first file format).
module sd_frame_unpacker #(
    parameter int P_PARAM_W = 800,
    parameter int P_PARAM_H = 600,
    parameter int FIFO_AW   = 7
) (
    input  logic        clk_ram,
    input  logic        reset,
    input  logic [23:0] in_address,
    input  logic [31:0] in_data,
    input  logic        in_wren,
    input  logic        file_finish,
    output logic [23:0] out_address,
    output logic [7:0]  out_data,
    output logic        out_wren,
    output logic        done,
    output logic        overflow,
    output logic        seq_err
);
    localparam int BPR   = (P_PARAM_W + 7) / 8;
    localparam int WPR   = (P_PARAM_W + 31) / 32;
    localparam int PBR   = 4 * WPR;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int COL_W = $clog2(PBR);
    localparam int ROW_W = $clog2(P_PARAM_H + 1);

    typedef enum logic [0:0] {ST_IDLE, ST_EMIT} state_t;

    function automatic logic [7:0] map_byte(input logic [7:0] b);
        logic [7:0] r;
`ifdef SD_UNPACK_BITREV_EN
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
`else
        r = b;
`endif
        return r;
    endfunction

    logic [31:0]        fifo_mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [23:0]        exp_idx_q, exp_idx_d, lin_q, lin_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [31:0]        sr_q, sr_d;
    logic [1:0]         bidx_q, bidx_d;
    state_t             state_q, state_d;
    logic               ff_q;
    logic [23:0]        out_address_d;
    logic [7:0]         out_data_d, byte_s;
    logic               out_wren_d, done_d, overflow_d, seq_err_d;
    logic               full_s, empty_s, restart_s, push_s, pop_s;

    assign full_s    = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign empty_s   = (count_q == '0);
    assign restart_s = ff_q & ~file_finish;
    assign byte_s    = sr_q[{bidx_q, 3'b000} +: 8];

    // Next-state logic: emitter FSM, byte placement, FIFO bookkeeping, restart.
    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bidx_d        = bidx_q;
        col_d         = col_q;
        row_d         = row_q;
        lin_d         = lin_q;
        out_address_d = out_address;
        out_data_d    = out_data;
        out_wren_d    = 1'b0;
        pop_s         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    sr_d    = fifo_mem_q[rd_ptr_q];
                    bidx_d  = 2'd0;
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                // Bytes past the row width or below the last row are padding/excess.
                if ((col_q < COL_W'(BPR)) && (row_q < ROW_W'(P_PARAM_H))) begin
                    out_wren_d    = 1'b1;
                    out_data_d    = map_byte(byte_s);
                    out_address_d = lin_q;
                    lin_d         = lin_q + 24'd1;
                end else begin
                    out_wren_d = 1'b0;
                end
                if (col_q == COL_W'(PBR - 1)) begin
                    col_d = '0;
                    if (row_q != ROW_W'(P_PARAM_H)) begin
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        row_d = row_q;
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
                if (bidx_q == 2'd3) begin
                    if (!empty_s) begin
                        pop_s  = 1'b1;
                        sr_d   = fifo_mem_q[rd_ptr_q];
                        bidx_d = 2'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bidx_d = bidx_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
        push_s     = in_wren & (~full_s | pop_s);
        wr_ptr_d   = push_s ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_s ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d    = count_q + (FIFO_AW + 1)'(push_s) - (FIFO_AW + 1)'(pop_s);
        exp_idx_d  = in_wren ? exp_idx_q + 24'd1 : exp_idx_q;
        overflow_d = overflow | (in_wren & ~push_s);
        seq_err_d  = seq_err | (in_wren & (in_address != exp_idx_q));
        done_d     = file_finish & empty_s & (state_q == ST_IDLE);

        if (restart_s) begin
            push_s     = 1'b0;
            state_d    = ST_IDLE;
            bidx_d     = 2'd0;
            col_d      = '0;
            row_d      = '0;
            lin_d      = 24'd0;
            out_wren_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            exp_idx_d  = 24'd0;
            overflow_d = 1'b0;
            seq_err_d  = 1'b0;
            done_d     = 1'b0;
        end else begin
            done_d = done_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk_ram) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= in_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= 32'd0;
            bidx_q      <= 2'd0;
            col_q       <= '0;
            row_q       <= '0;
            lin_q       <= 24'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            exp_idx_q   <= 24'd0;
            ff_q        <= 1'b0;
            out_address <= 24'd0;
            out_data    <= 8'd0;
            out_wren    <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bidx_q      <= bidx_d;
            col_q       <= col_d;
            row_q       <= row_d;
            lin_q       <= lin_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            exp_idx_q   <= exp_idx_d;
            ff_q        <= file_finish;
            out_address <= out_address_d;
            out_data    <= out_data_d;
            out_wren    <= out_wren_d;
            done        <= done_d;
            overflow    <= overflow_d;
            seq_err     <= seq_err_d;
        end
    end
endmodule

// File: tb/tb_sd_frame_unpacker.sv
// Bench for sd_frame_unpacker: a default 800x600 instance and a 40x2 instance share one stimulus.
module tb_sd_frame_unpacker;
    localparam int BPR_A = 100, PBR_A = 100, H_A = 600;
    localparam int BPR_B = 5,   PBR_B = 8,   H_B = 2;

    logic clk_ram = 1'b0;
    always #5 clk_ram = ~clk_ram;

    logic        reset, in_wren, file_finish;
    logic [23:0] in_address;
    logic [31:0] in_data;
    logic [23:0] a_addr, b_addr;
    logic [7:0]  a_data, b_data;
    logic        a_wren, b_wren, a_done, b_done, a_ovf, b_ovf, a_seq, b_seq;

    sd_frame_unpacker u_a (
        .clk_ram(clk_ram), .reset(reset), .in_address(in_address), .in_data(in_data),
        .in_wren(in_wren), .file_finish(file_finish), .out_address(a_addr), .out_data(a_data),
        .out_wren(a_wren), .done(a_done), .overflow(a_ovf), .seq_err(a_seq)
    );

    sd_frame_unpacker #(.P_PARAM_W(40), .P_PARAM_H(2)) u_b (
        .clk_ram(clk_ram), .reset(reset), .in_address(in_address), .in_data(in_data),
        .in_wren(in_wren), .file_finish(file_finish), .out_address(b_addr), .out_data(b_data),
        .out_wren(b_wren), .done(b_done), .overflow(b_ovf), .seq_err(b_seq)
    );

    int          nchecks = 0, nerr = 0;
    logic [31:0] qa[$], qb[$];
    int          pa = 0, pb = 0, tot_a = 0, tot_b = 0, ovf_base = 0, base_a, base_b;
    bit          sb_en = 1'b0, ovf_mode = 1'b0;
    logic [7:0]  e_byte [4];

    function automatic logic [7:0] tb_map(input logic [7:0] b);
        logic [7:0] r;
`ifdef SD_UNPACK_BITREV_EN
        for (int i = 0; i < 8; i++) r[i] = b[7 - i];
`else
        r = b;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected writes from the byte's position p in the padded stream: row = p/PBR, col = p%PBR.
    task automatic push_model(input logic [31:0] w);
        logic [7:0] byt;
        int         ad;
        for (int k = 0; k < 4; k++) begin
            byt = tb_map(w[8*k +: 8]);
            if ((pa % PBR_A) < BPR_A && (pa / PBR_A) < H_A) begin
                ad = (pa / PBR_A) * BPR_A + (pa % PBR_A);
                qa.push_back({ad[23:0], byt});
            end
            pa++;
            if ((pb % PBR_B) < BPR_B && (pb / PBR_B) < H_B) begin
                ad = (pb / PBR_B) * BPR_B + (pb % PBR_B);
                qb.push_back({ad[23:0], byt});
            end
            pb++;
        end
    endtask

    task automatic tick;
        @(posedge clk_ram);
        #1;
    endtask

    task automatic nxt;
        @(posedge clk_ram);
        @(negedge clk_ram);
    endtask

    task automatic send(input logic [23:0] ad, input logic [31:0] d, input bit model);
        in_address = ad;
        in_data    = d;
        in_wren    = 1'b1;
        if (model) push_model(d);
        tick();
        in_wren = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_a_addr"}, 32'(a_addr), 32'd0);
        chk({tag, "_a_data"}, 32'(a_data), 32'd0);
        chk({tag, "_a_wren"}, 32'(a_wren), 32'd0);
        chk({tag, "_a_done"}, 32'(a_done), 32'd0);
        chk({tag, "_a_ovf"},  32'(a_ovf),  32'd0);
        chk({tag, "_a_seq"},  32'(a_seq),  32'd0);
        chk({tag, "_b_wren"}, 32'(b_wren), 32'd0);
        chk({tag, "_b_done"}, 32'(b_done), 32'd0);
        chk({tag, "_b_ovf"},  32'(b_ovf),  32'd0);
        chk({tag, "_b_seq"},  32'(b_seq),  32'd0);
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        @(negedge clk_ram);
        while (!(a_done && b_done) && n < maxc) begin
            @(negedge clk_ram);
            n++;
        end
        chk("done_a", 32'(a_done), 32'd1);
        chk("done_b", 32'(b_done), 32'd1);
    endtask

    task automatic do_restart;
        file_finish = 1'b1;
        wait_done(3000);
        chk("sb_a_left", 32'(qa.size()), 32'd0);
        chk("sb_b_left", 32'(qb.size()), 32'd0);
        file_finish = 1'b0;
        tick();
        tick();
        @(negedge clk_ram);
        chk("restart_done_a", 32'(a_done), 32'd0);
        chk("restart_done_b", 32'(b_done), 32'd0);
        qa.delete();
        qb.delete();
        pa = 0;
        pb = 0;
    endtask

    // Every output cycle: scoreboard pop on each write strobe, or running-address check.
    task automatic compare_loop;
        logic [31:0] e;
        forever begin
            @(negedge clk_ram);
            if (a_wren) begin
                if (sb_en) begin
                    if (qa.size() == 0) begin
                        chk("sb_a_unexpected", 32'(a_addr), 32'hFFFF_FFFF);
                    end else begin
                        e = qa.pop_front();
                        chk("sb_a_addr", 32'(a_addr), 32'(e[31:8]));
                        chk("sb_a_data", 32'(a_data), 32'(e[7:0]));
                    end
                end else if (ovf_mode) begin
                    chk("ovf_a_addr", 32'(a_addr), 32'(tot_a - ovf_base));
                end
                tot_a++;
            end
            if (b_wren) begin
                if (sb_en) begin
                    if (qb.size() == 0) begin
                        chk("sb_b_unexpected", 32'(b_addr), 32'hFFFF_FFFF);
                    end else begin
                        e = qb.pop_front();
                        chk("sb_b_addr", 32'(b_addr), 32'(e[31:8]));
                        chk("sb_b_data", 32'(b_data), 32'(e[7:0]));
                    end
                end
                tot_b++;
            end
        end
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        in_wren     = 1'b0;
        file_finish = 1'b0;
        in_address  = 24'd0;
        in_data     = 32'd0;
`ifdef SD_UNPACK_BITREV_EN
        e_byte[0] = 8'h88; e_byte[1] = 8'h44; e_byte[2] = 8'hCC; e_byte[3] = 8'h22;
`else
        e_byte[0] = 8'h11; e_byte[1] = 8'h22; e_byte[2] = 8'h33; e_byte[3] = 8'h44;
`endif
        fork
            compare_loop();
        join_none

        // Reset and idle.
        repeat (3) tick();
        @(negedge clk_ram);
        chk_idle("in_reset");
        reset = 1'b0;
        repeat (20) tick();
        @(negedge clk_ram);
        chk_idle("idle");

        // Single word: latency and byte order, pinned by literals.
        sb_en = 1'b1;
        send(24'd0, 32'h4433_2211, 1'b1);
        @(negedge clk_ram);
        chk("lat_t0_wren", 32'(a_wren), 32'd0);
        nxt();
        chk("lat_t1_wren", 32'(a_wren), 32'd0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            chk("lat_wren", 32'(a_wren), 32'd1);
            chk("lat_addr", 32'(a_addr), 32'(k));
            chk("lat_data", 32'(a_data), 32'(e_byte[k]));
        end
        nxt();
        chk("lat_t6_wren", 32'(a_wren), 32'd0);
        do_restart();

        // Four words: row padding stripped on the 40-wide instance.
        base_a = tot_a;
        base_b = tot_b;
        for (int i = 0; i < 4; i++) begin
            send(24'(i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'b1);
        end
        repeat (30) tick();
        chk("rows_a_count", 32'(tot_a - base_a), 32'd16);
        chk("rows_b_count", 32'(tot_b - base_b), 32'd10);
        do_restart();

        // Address sequence error; data still written.
        base_a = tot_a;
        base_b = tot_b;
        send(24'd0, 32'hA3A2_A1A0, 1'b1);
        send(24'd1, 32'hB3B2_B1B0, 1'b1);
        @(negedge clk_ram);
        chk("seq_before_a", 32'(a_seq), 32'd0);
        send(24'd3, 32'hC3C2_C1C0, 1'b1);
        @(negedge clk_ram);
        chk("seq_after_a", 32'(a_seq), 32'd1);
        chk("seq_after_b", 32'(b_seq), 32'd1);
        repeat (30) tick();
        chk("seq_a_count", 32'(tot_a - base_a), 32'd12);
        chk("seq_b_count", 32'(tot_b - base_b), 32'd9);
        do_restart();
        chk("seq_cleared_a", 32'(a_seq), 32'd0);

        // Overflow: 200 back-to-back words into a 128-deep FIFO.
        sb_en    = 1'b0;
        ovf_base = tot_a;
        base_b   = tot_b;
        ovf_mode = 1'b1;
        for (int i = 0; i < 200; i++) send(24'(i), 32'(i), 1'b0);
        repeat (900) tick();
        @(negedge clk_ram);
        chk("ovf_a", 32'(a_ovf), 32'd1);
        chk("ovf_b", 32'(b_ovf), 32'd1);
        chk("ovf_seq_a", 32'(a_seq), 32'd0);
        chk("ovf_lt_800", 32'((tot_a - ovf_base) < 800), 32'd1);
        chk("ovf_gt_512", 32'((tot_a - ovf_base) > 512), 32'd1);
        chk("ovf_mult4", 32'((tot_a - ovf_base) % 4), 32'd0);
        chk("ovf_b_count", 32'(tot_b - base_b), 32'd10);
        ovf_mode    = 1'b0;
        file_finish = 1'b1;
        wait_done(2000);

        // Restart mid-EMIT: file_finish falls while bytes are being emitted.
        send(24'd0, 32'h8765_4321, 1'b0);
        n = 0;
        @(negedge clk_ram);
        while (!a_wren && n < 10) begin
            @(negedge clk_ram);
            n++;
        end
        chk("mid_emit_seen", 32'(a_wren), 32'd1);
        file_finish = 1'b0;
        nxt();
        chk("rst_wren_a", 32'(a_wren), 32'd0);
        chk("rst_wren_b", 32'(b_wren), 32'd0);
        chk("rst_ovf_a", 32'(a_ovf), 32'd0);
        chk("rst_ovf_b", 32'(b_ovf), 32'd0);
        chk("rst_seq_a", 32'(a_seq), 32'd0);
        chk("rst_done_a", 32'(a_done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("rst_quiet_a", 32'(a_wren), 32'd0);
        end
        qa.delete();
        qb.delete();
        pa    = 0;
        pb    = 0;
        sb_en = 1'b1;
        send(24'd0, 32'hDDCC_BBAA, 1'b1);
        repeat (10) tick();
        @(negedge clk_ram);
        chk("post_rst_a_left", 32'(qa.size()), 32'd0);
        chk("post_rst_b_left", 32'(qb.size()), 32'd0);
        chk("post_rst_seq_a", 32'(a_seq), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
